// File: rtl/mem_stage.sv
// MEM pipeline stage: consumes the EX/MEM latch, resolves control flow, runs the
// data-cache request handshake for lw/sw and registers the MEM/WB latch.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rdat1_i,
  input  logic [31:0] rdat2_i,
  input  logic [31:0] extout_i,
  input  logic [31:0] Jaddr_i,
  input  logic [31:0] npc_i,
  input  logic [4:0]  wsel_i,
  input  logic        RegW_i,
  input  logic        DRen_i,
  input  logic        DWen_i,
  input  logic        Branch_i,
  input  logic        BNE_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic        zero_i,
  input  logic        halt_i,
  input  logic [1:0]  Mem_i,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        memwb_valid,
  output logic        memwb_RegW,
  output logic        memwb_halt,
  output logic [4:0]  memwb_wsel,
  output logic [31:0] memwb_wdat,
  output logic        halted_o,
  output logic        err_o
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic        wb_valid_d, wb_regw_d, wb_halt_d;
  logic [4:0]  wb_wsel_d;
  logic [31:0] wb_wdat_d;

  logic        act, memop, taken;
  logic [31:0] sel_wdat;

  assign act       = valid_i & ~flush_i & ~halted_q;
  assign memop     = act & (DRen_i | DWen_i);
  assign taken     = Branch_i & (BNE_i ? ~zero_i : zero_i);
  assign dmemaddr  = alu_out_i;
  assign dmemstore = rdat2_i;
  assign halted_o  = halted_q;
  assign err_o     = err_q;
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Load data is only meaningful once the cache has acknowledged.
  always_comb begin
    sel_wdat = '0;
    unique case (Mem_i)
      2'b00:   sel_wdat = alu_out_i;
      2'b01:   sel_wdat = (state_q == StAccess) ? dmemload : 32'd0;
      2'b10:   sel_wdat = npc_i;
      default: sel_wdat = extout_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    wb_valid_d = 1'b0;
    wb_regw_d  = 1'b0;
    wb_halt_d  = 1'b0;
    wb_wsel_d  = '0;
    wb_wdat_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          stall_o = 1'b1;
          state_d = StAccess;
          cnt_d   = '0;
        end else if (act) begin
          wb_valid_d = 1'b1;
          wb_regw_d  = RegW_i;
          wb_halt_d  = halt_i;
          wb_wsel_d  = wsel_i;
          wb_wdat_d  = sel_wdat;
        end
      end
      StAccess: begin
        // The access is committed here, so flush_i has no effect.
        dmemREN = DRen_i;
        dmemWEN = DWen_i;
        if (dhit) begin
          state_d    = StIdle;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_regw_d  = RegW_i;
          wb_halt_d  = halt_i;
          wb_wsel_d  = wsel_i;
          wb_wdat_d  = sel_wdat;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    redirect_o = act & ~stall_o & (taken | jump_i | jr_i);
    target_o   = '0;
    if (redirect_o) begin
      if (jr_i)        target_o = rdat1_i;
      else if (jump_i) target_o = Jaddr_i;
      else             target_o = npc_i + (extout_i << 2);
    end
  end

  always_comb begin
    halted_d = halted_q | wb_halt_d;
    err_d    = err_q;
    if (state_q == StAccess && ((cnt_q == TimeoutCnt) || (!dhit && cnt_inc == TimeoutCnt))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      memwb_valid <= 1'b0;
      memwb_RegW  <= 1'b0;
      memwb_halt  <= 1'b0;
      memwb_wsel  <= '0;
      memwb_wdat  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      memwb_valid <= wb_valid_d;
      memwb_RegW  <= wb_regw_d;
      memwb_halt  <= wb_halt_d;
      memwb_wsel  <= wb_wsel_d;
      memwb_wdat  <= wb_wdat_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver checks handshake/redirect per cycle and queues
// expected MEM/WB writes; a monitor pops them whenever memwb_valid is presented.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        CLK, RST;
  logic        valid_i, flush_i;
  logic [31:0] alu_out_i, rdat1_i, rdat2_i, extout_i, Jaddr_i, npc_i;
  logic [4:0]  wsel_i;
  logic        RegW_i, DRen_i, DWen_i, Branch_i, BNE_i, jump_i, jr_i, zero_i, halt_i;
  logic [1:0]  Mem_i;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        stall_o, redirect_o;
  logic [31:0] target_o;
  logic        memwb_valid, memwb_RegW, memwb_halt;
  logic [4:0]  memwb_wsel;
  logic [31:0] memwb_wdat;
  logic        halted_o, err_o;

  mem_stage #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .flush_i(flush_i),
    .alu_out_i(alu_out_i), .rdat1_i(rdat1_i), .rdat2_i(rdat2_i), .extout_i(extout_i),
    .Jaddr_i(Jaddr_i), .npc_i(npc_i), .wsel_i(wsel_i), .RegW_i(RegW_i),
    .DRen_i(DRen_i), .DWen_i(DWen_i), .Branch_i(Branch_i), .BNE_i(BNE_i),
    .jump_i(jump_i), .jr_i(jr_i), .zero_i(zero_i), .halt_i(halt_i), .Mem_i(Mem_i),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall_o(stall_o),
    .redirect_o(redirect_o), .target_o(target_o), .memwb_valid(memwb_valid),
    .memwb_RegW(memwb_RegW), .memwb_halt(memwb_halt), .memwb_wsel(memwb_wsel),
    .memwb_wdat(memwb_wdat), .halted_o(halted_o), .err_o(err_o)
  );

  typedef struct packed {
    logic        valid, flush;
    logic [31:0] alu, rdat1, rdat2, ext, jaddr, npc;
    logic [4:0]  wsel;
    logic        regw, dren, dwen, branch, bne, jump, jr, zero, halt;
    logic [1:0]  mem;
  } instr_t;

  typedef struct packed {
    logic        regw, halt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } wb_t;

  wb_t wb_q[$];
  wb_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  halted_m = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model, written from the stage's architectural rules.
  function automatic logic [31:0] ref_wdat(input instr_t t, input logic [31:0] load);
    case (t.mem)
      2'd0:    return t.alu;
      2'd1:    return load;
      2'd2:    return t.npc;
      default: return t.ext;
    endcase
  endfunction

  function automatic logic ref_redirect(input instr_t t);
    logic taken;
    taken = t.branch && (t.bne ? !t.zero : t.zero);
    return taken || t.jump || t.jr;
  endfunction

  function automatic logic [31:0] ref_target(input instr_t t);
    if (t.jr)   return t.rdat1;
    if (t.jump) return t.jaddr;
    return t.npc + t.ext * 32'd4;
  endfunction

  task automatic apply(input instr_t t);
    valid_i = t.valid;  flush_i = t.flush;  alu_out_i = t.alu;  rdat1_i = t.rdat1;
    rdat2_i = t.rdat2;  extout_i = t.ext;   Jaddr_i = t.jaddr;  npc_i = t.npc;
    wsel_i = t.wsel;    RegW_i = t.regw;    DRen_i = t.dren;    DWen_i = t.dwen;
    Branch_i = t.branch; BNE_i = t.bne;     jump_i = t.jump;    jr_i = t.jr;
    zero_i = t.zero;    halt_i = t.halt;    Mem_i = t.mem;
  endtask

  // flush_mode during ACCESS: 0 none, 1 random, 2 always.
  task automatic issue(input instr_t t, input int waits, input logic [31:0] load,
                       input int flush_mode);
    logic act;
    wb_t  e;
    act = t.valid && !t.flush && !halted_m;
    @(posedge CLK); #1;
    apply(t);
    dhit = 1'b0;
    dmemload = load;
    @(negedge CLK);
    chk("halted", halted_o, halted_m);
    if (act && (t.dren || t.dwen)) begin
      chk("idle_stall", stall_o, 1);
      chk("idle_ren", dmemREN, 0);
      chk("idle_wen", dmemWEN, 0);
      chk("idle_redirect", redirect_o, 0);
      for (int k = 0; k <= waits; k++) begin
        @(posedge CLK); #1;
        dhit = (k == waits);
        if (flush_mode == 1) flush_i = 1'($urandom_range(0, 1));
        if (flush_mode == 2) flush_i = 1'b1;
        @(negedge CLK);
        chk("acc_stall", stall_o, (k != waits));
        chk("acc_ren", dmemREN, t.dren);
        chk("acc_wen", dmemWEN, t.dwen);
        chk("acc_addr", dmemaddr, t.alu);
        if (t.dwen) chk("acc_store", dmemstore, t.rdat2);
        chk("acc_redirect", redirect_o, 0);
        if (k == waits) begin
          e.regw = t.regw; e.halt = t.halt; e.wsel = t.wsel; e.wdat = ref_wdat(t, load);
          wb_q.push_back(e);
          if (t.halt) halted_m = 1;
        end
      end
    end else begin
      chk("stall", stall_o, 0);
      chk("ren", dmemREN, 0);
      chk("wen", dmemWEN, 0);
      chk("redirect", redirect_o, act && ref_redirect(t));
      chk("target", target_o, (act && ref_redirect(t)) ? ref_target(t) : 32'd0);
      if (act) begin
        e.regw = t.regw; e.halt = t.halt; e.wsel = t.wsel;
        e.wdat = (t.mem == 2'd1) ? 32'd0 : ref_wdat(t, 32'd0);
        wb_q.push_back(e);
        if (t.halt) halted_m = 1;
      end
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t = '0;
    t.valid = ($urandom_range(0, 7) != 0);
    t.flush = ($urandom_range(0, 7) == 0);
    t.alu = $urandom; t.rdat1 = $urandom; t.rdat2 = $urandom; t.ext = $urandom;
    t.jaddr = $urandom; t.npc = $urandom; t.wsel = 5'($urandom);
    case ($urandom_range(0, 5))
      0: begin t.mem = 2'($urandom); t.regw = 1'($urandom); end
      1: begin t.dren = 1; t.mem = 2'd1; t.regw = 1; end
      2: begin t.dwen = 1; t.mem = 2'($urandom); end
      3: begin t.branch = 1; t.bne = 1'($urandom); t.zero = 1'($urandom); end
      4: begin t.jump = 1; t.jr = 1'($urandom); end
      default: t.jr = 1;
    endcase
    return t;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (memwb_valid) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", memwb_valid, 0);
        end else begin
          mon_e = wb_q.pop_front();
          chk("wb_regw", memwb_RegW, mon_e.regw);
          chk("wb_halt", memwb_halt, mon_e.halt);
          chk("wb_wsel", memwb_wsel, mon_e.wsel);
          chk("wb_wdat", memwb_wdat, mon_e.wdat);
        end
      end else begin
        chk("bubble", {memwb_RegW, memwb_halt, memwb_wsel, memwb_wdat}, 0);
      end
    end
  end

  instr_t t;

  initial begin
    t = '0;
    apply(t);
    dhit = 0; dmemload = 0; RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_valid", memwb_valid, 0);
    chk("rst_wdat", memwb_wdat, 0);
    chk("rst_wsel", memwb_wsel, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);

    // add result
    t = '0; t.valid = 1; t.alu = 32'h10; t.regw = 1; t.wsel = 5'd5;
    issue(t, 0, 0, 0);
    // lw with three ACCESS cycles
    t = '0; t.valid = 1; t.alu = 32'h40; t.dren = 1; t.mem = 2'd1; t.regw = 1; t.wsel = 5'd9;
    issue(t, 2, 32'hDEADBEEF, 0);
    // sw with immediate hit
    t = '0; t.valid = 1; t.alu = 32'h80; t.dwen = 1; t.rdat2 = 32'h1234;
    issue(t, 0, 0, 0);
    // beq taken, bne not taken, jr
    t = '0; t.valid = 1; t.branch = 1; t.zero = 1; t.npc = 32'h100; t.ext = 32'h3;
    issue(t, 0, 0, 0);
    t.bne = 1;
    issue(t, 0, 0, 0);
    t = '0; t.valid = 1; t.jr = 1; t.rdat1 = 32'h200; t.jump = 1; t.jaddr = 32'h300;
    issue(t, 0, 0, 0);
    // flush during ACCESS is ignored; flush in IDLE squashes a jump
    t = '0; t.valid = 1; t.alu = 32'h44; t.dren = 1; t.mem = 2'd1; t.regw = 1; t.wsel = 5'd3;
    issue(t, 1, 32'hCAFEF00D, 2);
    t = '0; t.valid = 1; t.flush = 1; t.jump = 1; t.jaddr = 32'h500; t.regw = 1;
    issue(t, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      t = rand_instr();
      issue(t, $urandom_range(0, 2), $urandom, 1);
    end
    chk("no_err_yet", err_o, 0);

    // dhit never arrives: err after TO stalled ACCESS cycles, then reset mid-access
    t = '0; t.valid = 1; t.alu = 32'h60; t.dren = 1; t.mem = 2'd1; t.regw = 1;
    @(posedge CLK); #1;
    apply(t); dhit = 0;
    @(negedge CLK);
    chk("to_idle_stall", stall_o, 1);
    for (int k = 1; k <= TO + 2; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("to_stall", stall_o, 1);
      chk("to_ren", dmemREN, 1);
      chk("to_err", err_o, (k >= TO + 1));
    end
    @(posedge CLK); #1;
    RST = 1; valid_i = 0;
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    chk("rst_acc_ren", dmemREN, 0);
    chk("rst_acc_stall", stall_o, 0);
    chk("rst_acc_err", err_o, 0);
    chk("rst_acc_valid", memwb_valid, 0);

    // halt, then everything is suppressed
    t = '0; t.valid = 1; t.halt = 1; t.alu = 32'h7;
    issue(t, 0, 0, 0);
    t = '0; t.valid = 1; t.alu = 32'h70; t.dren = 1; t.mem = 2'd1; t.regw = 1;
    issue(t, 0, 32'h1, 0);
    t = '0; t.valid = 1; t.jump = 1; t.jaddr = 32'h900;
    issue(t, 0, 0, 0);

    @(posedge CLK); #1;
    t = '0; apply(t); dhit = 0;
    repeat (3) @(negedge CLK);
    chk("wb_drain", wb_q.size(), 0);
    chk("halted_final", halted_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
